// File: rtl/ucnt_event16_if.sv
// Event stream between ucnt_event16 and its consumer.
// The producer presents the FIFO head. The consumer answers with evt_ready.
interface ucnt_event16_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_type;
  logic [15:0] evt_data;

  modport master (
    output evt_valid,
    output evt_type,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_type,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/ucnt_event16.sv
// Event detector for a 16-bit counter. It detects overflow, compare-match and capture edges.
// Detected events go into a 4-deep FIFO, and lost events are counted in drop_cnt.
module ucnt_event16 (
  input  logic                   clk,
  input  logic                   _areset,
  input  logic [15:0]            dcount_top,
  input  logic                   overflow,
  input  logic [15:0]            cmp_val,
  input  logic                   cmp_en,
  input  logic                   _cap,
  ucnt_event16_if.master         evt,
  output logic                   match,
  output logic [7:0]             drop_cnt
);

  localparam logic [1:0] TYPE_MATCH = 2'b01;
  localparam logic [1:0] TYPE_OVF   = 2'b10;
  localparam logic [1:0] TYPE_CAP   = 2'b11;

  logic        prev_ovf;
  logic        prev_eq;
  logic        prev_cap;
  logic        eq_term;
  logic        ovf_evt;
  logic        match_evt;
  logic        cap_evt;
  logic        push_req;
  logic [1:0]  push_type;
  logic [1:0]  n_evt;
  logic [1:0]  sim_drop;
  logic        fifo_drop;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  logic [17:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        full;
  logic        pop;
  logic        push;

  // prev_eq resets to 1 so a count already equal to cmp_val after reset is not reported as a match
  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      prev_ovf <= 1'b0;
      prev_eq  <= 1'b1;
      prev_cap <= 1'b1;
      match    <= 1'b0;
    end else begin
      prev_ovf <= overflow;
      prev_eq  <= eq_term;
      prev_cap <= _cap;
      match    <= match_evt;
    end
  end

  always_comb begin
    eq_term   = cmp_en && (dcount_top == cmp_val);
    ovf_evt   = overflow && !prev_ovf;
    match_evt = eq_term && !prev_eq;
    cap_evt   = !_cap && prev_cap;
    push_req  = ovf_evt || match_evt || cap_evt;
    push_type = 2'b00;
    if (ovf_evt)        push_type = TYPE_OVF;
    else if (match_evt) push_type = TYPE_MATCH;
    else if (cap_evt)   push_type = TYPE_CAP;
    n_evt     = {1'b0, ovf_evt} + {1'b0, match_evt} + {1'b0, cap_evt};
    sim_drop  = (n_evt == 2'd0) ? 2'd0 : n_evt - 2'd1;
  end

  // A full FIFO can still accept a push when it pops on the same edge
  always_comb begin
    full      = (count == 3'd4);
    pop       = evt.evt_valid && evt.evt_ready;
    push      = push_req && (!full || pop);
    fifo_drop = push_req && !push;
    drop_inc  = sim_drop + {1'b0, fifo_drop};
    drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_inc};
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_type, dcount_top};
  end

  // Head outputs are forced to zero while empty so that reset clears them immediately
  always_comb begin
    evt.evt_valid = (count != 3'd0);
    evt.evt_type  = 2'b00;
    evt.evt_data  = 16'h0000;
    if (evt.evt_valid) begin
      evt.evt_type = fifo_mem[rd_ptr][17:16];
      evt.evt_data = fifo_mem[rd_ptr][15:0];
    end
  end

endmodule

// File: doc/ucnt_event16.md
UCNT_EVENT16 -- requirements
Module: ucnt_event16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock; it SHALL be the same clock that drives the 16-bit counter stage.
REQ-003 Port _areset, input, 1: asynchronous active-low reset.
REQ-004 Port dcount_top, input, 16: counter value from the upstream 16-bit up/down counter.
REQ-005 Port overflow, input, 1: counter overflow flag from the upstream counter.
REQ-006 Port cmp_val, input, 16: compare value.
REQ-007 Port cmp_en, input, 1: compare enable, active-high.
REQ-008 Port _cap, input, 1: synchronous capture request, active-low.
REQ-009 Port evt_ready, input, 1: consumer accepts the head event.
REQ-010 Port evt_valid, output, 1: the head event is valid.
REQ-011 Port evt_type, output, 2: 01 = match, 10 = overflow, 11 = capture; 00 is never emitted while valid.
REQ-012 Port evt_data, output, 16: dcount_top sampled in the cycle the event was detected.
REQ-013 Port match, output, 1: registered one-cycle pulse on each compare-match detection.
REQ-014 Port drop_cnt, output, 8: saturating count of lost events.

Function
REQ-015 Overflow event: SHALL be detected in the cycle where overflow=1 and the registered previous overflow=0 (rising edge only).
REQ-016 Match event: SHALL be detected in the cycle where cmp_en=1, dcount_top==cmp_val, and the previous-cycle equality term was 0.
- A counter held at cmp_val (wrap-stop or stall) SHALL produce exactly one match.
REQ-017 Capture event: SHALL be detected on the cycle _cap is low and was high the previous cycle.
REQ-018 At most one event SHALL be enqueued per cycle, priority overflow > match > capture.
- Each simultaneous lower-priority event SHALL increment drop_cnt by 1 (up to +2 per cycle, saturating at 255).
REQ-019 The match pulse SHALL assert one cycle after detection, independent of queueing and drops.
REQ-020 Events SHALL be buffered in a 4-entry FIFO of {evt_type, evt_data}.
- evt_valid SHALL equal not-empty.
- evt_type and evt_data SHALL present the FIFO head.
REQ-021 Latency: an event detected in cycle N with the FIFO empty SHALL appear with evt_valid=1 at cycle N+1.
REQ-022 Pop SHALL occur on a clock edge where evt_valid=1 and evt_ready=1.
- While evt_valid=1 and evt_ready=0, evt_type and evt_data SHALL hold stable.
REQ-023 Push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the event is dropped and drop_cnt increments by 1 (saturating).
REQ-024 Simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-025 drop_cnt SHALL saturate at 8'hFF and never wrap; it SHALL be cleared only by reset.
REQ-026 Changing cmp_val or cmp_en SHALL take effect in the same cycle for detection.
- A cmp_val change onto the current count SHALL count as an equality edge.

Reset
REQ-027 On _areset=0, the following SHALL clear asynchronously: evt_valid=0, evt_type=00, evt_data=0, match=0, drop_cnt=0, FIFO empty.
REQ-028 Reset state of edge registers: previous overflow=0, previous equality=1, previous _cap=1.
- No match event SHALL be generated in the first cycle after reset even if dcount_top==cmp_val.
REQ-029 Reset asserted mid-operation SHALL discard all queued events.
- No event SHALL be emitted for any input condition present only during reset.

Verification
REQ-030 cmp_en=1, cmp_val=16'h0005, counter counts up from 0 -> match pulse one cycle after dcount_top=0005; event {01, 0005} valid next cycle; counter stalled at 0005 -> no second event.
REQ-031 overflow rises with dcount_top=16'hFFFF and cmp_en=0 -> {10, FFFF} at N+1; overflow held high 3 cycles -> only one event.
REQ-032 overflow edge, match and _cap falling all in one cycle -> only {10, data} queued; drop_cnt=2; match pulse still asserted.
REQ-033 evt_ready=0, six capture edges -> 4 events queued with head stable, drop_cnt=2; then evt_ready=1 with a new capture in the same cycle as a pop while full -> capture accepted, occupancy stays 4.
REQ-034 drop_cnt preset to 254 via overflow drops, then 3 more drops -> drop_cnt=255 and holds.
REQ-035 _areset pulsed low with 3 events queued -> evt_valid=0 and drop_cnt=0 immediately; after release with dcount_top==cmp_val and cmp_en=1 -> no match event.
